// File: rtl/fet_gate_sequencer_if.sv
// FET request / gate-drive bundle between the protection monitor and the
// gate sequencer. The monitor side (master) drives requests and alert; the
// sequencer side (slave) drives the gates and its status.
interface fet_gate_sequencer_if;
  // Raw requests from the protection monitor
  logic       chg_on;
  logic       dsg_on;
  logic       pchg_on;
  logic       pdsg_on;
  logic       alert;
  // Gate drives and status back towards the power stage / system
  logic       gate_chg;
  logic       gate_dsg;
  logic       gate_pchg;
  logic       gate_pdsg;
  logic       fault_lock;
  logic [1:0] c_state;
  logic [1:0] d_state;

  modport master (
    output chg_on, dsg_on, pchg_on, pdsg_on, alert,
    input  gate_chg, gate_dsg, gate_pchg, gate_pdsg, fault_lock, c_state, d_state
  );

  modport slave (
    input  chg_on, dsg_on, pchg_on, pdsg_on, alert,
    output gate_chg, gate_dsg, gate_pchg, gate_pdsg, fault_lock, c_state, d_state
  );
endinterface

// File: rtl/fet_gate_sequencer.sv
// FET gate sequencer: debounces the monitor's FET requests, sequences
// precharge -> dead time -> charge and predischarge -> discharge, and forces
// every gate off while an alert-driven fault lockout is active.
// All gate drives are registered and derived from the next FSM state, so a
// gate changes on the same edge as the state that owns it.
module fet_gate_sequencer #(
  parameter int unsigned DEB_CYC    = 2,
  parameter int unsigned DEAD_CYC   = 2,
  parameter int unsigned PDSG_CYC   = 8,
  parameter int unsigned FAULT_HOLD = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fet_gate_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    C_OFF  = 2'd0,
    C_PCHG = 2'd1,
    C_DEAD = 2'd2,
    C_ON   = 2'd3
  } c_state_e;

  typedef enum logic [1:0] {
    D_OFF  = 2'd0,
    D_PDSG = 2'd1,
    D_ON   = 2'd2,
    D_BAD  = 2'd3
  } d_state_e;

  // Counter constants, sized to the counter width
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] PDSG_FULL = CNT_W'(PDSG_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FAULT_HOLD - 1);

  // Request bit positions in the debounce vectors
  localparam int unsigned R_CHG  = 0;
  localparam int unsigned R_DSG  = 1;
  localparam int unsigned R_PCHG = 2;
  localparam int unsigned R_PDSG = 3;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [3:0]            raw_s;
  logic [3:0]            filt_q, filt_d;
  logic [3:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  assign raw_s = {bus.pdsg_on, bus.pchg_on, bus.dsg_on, bus.chg_on};

  // Per-request filter: count consecutive samples that disagree with the
  // filtered value; the DEB_CYC-th such sample commits the new value.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (raw_s[i] == filt_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] >= DEB_LAST) begin
        filt_d[i]    = raw_s[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q    <= '0;
      deb_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  logic chg_req_s, dsg_req_s, pchg_req_s, pdsg_req_s;
  assign chg_req_s  = filt_q[R_CHG];
  assign dsg_req_s  = filt_q[R_DSG];
  assign pchg_req_s = filt_q[R_PCHG];
  assign pdsg_req_s = filt_q[R_PDSG];

  // ---------------------------------------------------------------------------
  // Fault lockout
  // ---------------------------------------------------------------------------
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             block_s;

  // Alert sets the lock at once; the lock clears after FAULT_HOLD
  // consecutive alert-free edges, any alert restarting the count.
  always_comb begin
    lock_d     = lock_q;
    hold_cnt_d = hold_cnt_q;
    if (bus.alert) begin
      lock_d     = 1'b1;
      hold_cnt_d = '0;
    end else if (lock_q) begin
      if (hold_cnt_q >= HOLD_LAST) begin
        lock_d     = 1'b0;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + CNT_ONE;
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  // Fault lockout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      lock_q     <= lock_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // A live alert overrides the FSMs in the same cycle; the lock keeps them
  // parked until it clears, so they resume one edge after release.
  assign block_s = bus.alert | lock_q;

  // ---------------------------------------------------------------------------
  // Charge FSM
  // ---------------------------------------------------------------------------
  c_state_e         c_state_q, c_state_d;
  logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;

  // Charge FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state_q  <= C_OFF;
      dead_cnt_q <= '0;
    end else begin
      c_state_q  <= c_state_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  // Charge FSM next state: PCHG hands over to CHG only through DEAD_CYC
  // cycles with both charge-path gates off.
  always_comb begin
    c_state_d  = c_state_q;
    dead_cnt_d = dead_cnt_q;
    if (block_s) begin
      c_state_d  = C_OFF;
      dead_cnt_d = '0;
    end else begin
      case (c_state_q)
        C_OFF: begin
          if (chg_req_s) begin
            c_state_d = C_ON;
          end else if (pchg_req_s) begin
            c_state_d = C_PCHG;
          end else begin
            c_state_d = C_OFF;
          end
        end
        C_PCHG: begin
          if (chg_req_s) begin
            c_state_d  = C_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end else if (!pchg_req_s) begin
            c_state_d = C_OFF;
          end else begin
            c_state_d = C_PCHG;
          end
        end
        C_DEAD: begin
          if (!chg_req_s) begin
            c_state_d  = C_OFF;
            dead_cnt_d = '0;
          end else if (dead_cnt_q <= CNT_ONE) begin
            // This decrement reaches zero: dead time is complete
            c_state_d  = C_ON;
            dead_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q - CNT_ONE;
          end
        end
        C_ON: begin
          if (!chg_req_s) begin
            c_state_d = C_OFF;
          end else begin
            c_state_d = C_ON;
          end
        end
        default: begin
          c_state_d  = C_OFF;
          dead_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Discharge FSM
  // ---------------------------------------------------------------------------
  d_state_e         d_state_q, d_state_d;
  logic [CNT_W-1:0] pdsg_cnt_q, pdsg_cnt_d;
  logic [CNT_W-1:0] pdsg_inc_s;

  // Count of PDSG cycles including the current one, saturating at PDSG_CYC
  assign pdsg_inc_s = (pdsg_cnt_q >= PDSG_FULL) ? PDSG_FULL : (pdsg_cnt_q + CNT_ONE);

  // Discharge FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state_q  <= D_OFF;
      pdsg_cnt_q <= '0;
    end else begin
      d_state_q  <= d_state_d;
      pdsg_cnt_q <= pdsg_cnt_d;
    end
  end

  // Discharge FSM next state: DSG may follow PDSG only after PDSG has been
  // driven for PDSG_CYC cycles.
  always_comb begin
    d_state_d  = d_state_q;
    pdsg_cnt_d = pdsg_cnt_q;
    if (block_s) begin
      d_state_d  = D_OFF;
      pdsg_cnt_d = '0;
    end else begin
      case (d_state_q)
        D_OFF: begin
          pdsg_cnt_d = '0;
          if (dsg_req_s && !pdsg_req_s) begin
            d_state_d = D_ON;
          end else if (pdsg_req_s) begin
            d_state_d = D_PDSG;
          end else begin
            d_state_d = D_OFF;
          end
        end
        D_PDSG: begin
          pdsg_cnt_d = pdsg_inc_s;
          if (dsg_req_s && (pdsg_inc_s == PDSG_FULL)) begin
            d_state_d  = D_ON;
            pdsg_cnt_d = '0;
          end else if (!dsg_req_s && !pdsg_req_s) begin
            d_state_d  = D_OFF;
            pdsg_cnt_d = '0;
          end else begin
            d_state_d = D_PDSG;
          end
        end
        D_ON: begin
          if (!dsg_req_s) begin
            d_state_d = D_OFF;
          end else begin
            d_state_d = D_ON;
          end
        end
        default: begin
          // Unused encoding: recover to OFF with the discharge path dark
          d_state_d  = D_OFF;
          pdsg_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Gate drives
  // ---------------------------------------------------------------------------
  logic gate_chg_q,  gate_chg_d;
  logic gate_pchg_q, gate_pchg_d;
  logic gate_dsg_q,  gate_dsg_d;
  logic gate_pdsg_q, gate_pdsg_d;

  // Gate decode from the next FSM states; CHG and PCHG are one-hot by state
  always_comb begin
    gate_chg_d  = 1'b0;
    gate_pchg_d = 1'b0;
    gate_dsg_d  = 1'b0;
    gate_pdsg_d = 1'b0;
    case (c_state_d)
      C_PCHG:  gate_pchg_d = 1'b1;
      C_ON:    gate_chg_d  = 1'b1;
      default: begin
        gate_chg_d  = 1'b0;
        gate_pchg_d = 1'b0;
      end
    endcase
    case (d_state_d)
      D_PDSG:  gate_pdsg_d = 1'b1;
      D_ON:    gate_dsg_d  = 1'b1;
      default: begin
        gate_dsg_d  = 1'b0;
        gate_pdsg_d = 1'b0;
      end
    endcase
  end

  // Registered gate drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_chg_q  <= 1'b0;
      gate_pchg_q <= 1'b0;
      gate_dsg_q  <= 1'b0;
      gate_pdsg_q <= 1'b0;
    end else begin
      gate_chg_q  <= gate_chg_d;
      gate_pchg_q <= gate_pchg_d;
      gate_dsg_q  <= gate_dsg_d;
      gate_pdsg_q <= gate_pdsg_d;
    end
  end

  assign bus.gate_chg   = gate_chg_q;
  assign bus.gate_pchg  = gate_pchg_q;
  assign bus.gate_dsg   = gate_dsg_q;
  assign bus.gate_pdsg  = gate_pdsg_q;
  assign bus.fault_lock = lock_q;
  assign bus.c_state    = c_state_q;
  assign bus.d_state    = d_state_q;

endmodule

// File: tb/tb_fet_gate_sequencer.sv
// Directed bench for fet_gate_sequencer with default parameters
// (DEB_CYC=2, DEAD_CYC=2, PDSG_CYC=8, FAULT_HOLD=16).
// Gate word bits: [3] chg, [2] dsg, [1] pchg, [0] pdsg.
// State word bits: [3:2] c_state, [1:0] d_state.
module tb_fet_gate_sequencer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic excl_seen;

  fet_gate_sequencer_if bus_if ();

  fet_gate_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] gates_w;
  logic [7:0] state_w;
  logic [7:0] lock_w;
  assign gates_w = {4'd0, bus_if.gate_chg, bus_if.gate_dsg, bus_if.gate_pchg, bus_if.gate_pdsg};
  assign state_w = {4'd0, bus_if.c_state, bus_if.d_state};
  assign lock_w  = {7'd0, bus_if.fault_lock};

  // Record any cycle where CHG and PCHG are driven together
  initial excl_seen = 1'b0;
  always @(negedge clk) begin
    if (bus_if.gate_chg && bus_if.gate_pchg) excl_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic c, input logic d, input logic pc, input logic pd);
    bus_if.chg_on  = c;
    bus_if.dsg_on  = d;
    bus_if.pchg_on = pc;
    bus_if.pdsg_on = pd;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus_if.alert = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check_eq("rst_gates", gates_w, 8'h00);
    check_eq("rst_state", state_w, 8'h00);
    check_eq("rst_lock",  lock_w,  8'h00);
    rst_n = 1'b1;
    ticks(2);

    // Reset in the middle of PDSG
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(3);
    check_eq("pdsg_enter", gates_w, 8'h01);
    ticks(4);
    check_eq("pdsg_mid_state", state_w, 8'h01);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_gates", gates_w, 8'h00);
    check_eq("async_rst_state", state_w, 8'h00);
    #1;
    rst_n = 1'b1;
    // pdsg still high, dsg joins: PDSG must run a full 8 cycles from scratch
    set_req(1'b0, 1'b1, 1'b0, 1'b1);
    ticks(2);
    check_eq("post_rst_filter_wait", gates_w, 8'h00);
    ticks(1);
    check_eq("pdsg_first", gates_w, 8'h01);
    ticks(7);
    check_eq("pdsg_eighth", gates_w, 8'h01);
    check_eq("pdsg_eighth_state", state_w, 8'h01);
    ticks(1);
    check_eq("dsg_after_pdsg", gates_w, 8'h04);
    check_eq("dsg_after_pdsg_state", state_w, 8'h02);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check_eq("dsg_off", state_w, 8'h00);

    // dsg dropped mid-PDSG with pdsg held: stays in PDSG
    set_req(1'b0, 1'b1, 1'b0, 1'b1);
    ticks(3);
    ticks(4);
    bus_if.dsg_on = 1'b0;
    ticks(10);
    check_eq("pdsg_hold_no_dsg", gates_w, 8'h01);
    check_eq("pdsg_hold_state", state_w, 8'h01);
    bus_if.pdsg_on = 1'b0;
    ticks(3);
    check_eq("pdsg_both_drop", state_w, 8'h00);
    check_eq("pdsg_both_drop_gates", gates_w, 8'h00);

    // CHG debounce latency: first sampling edge N, gate after N+2
    bus_if.chg_on = 1'b1;
    ticks(1);
    check_eq("chg_lat_n", gates_w, 8'h00);
    ticks(1);
    check_eq("chg_lat_n1", gates_w, 8'h00);
    ticks(1);
    check_eq("chg_lat_n2", gates_w, 8'h08);
    check_eq("chg_lat_state", state_w, 8'h0C);
    bus_if.chg_on = 1'b0;
    ticks(3);
    check_eq("chg_off", gates_w, 8'h00);
    // one-cycle glitch is filtered out
    bus_if.chg_on = 1'b1;
    ticks(1);
    bus_if.chg_on = 1'b0;
    ticks(4);
    check_eq("chg_glitch_gates", gates_w, 8'h00);
    check_eq("chg_glitch_state", state_w, 8'h00);

    // PCHG -> DEAD (2 cycles) -> CHG handover
    bus_if.pchg_on = 1'b1;
    ticks(3);
    check_eq("pchg_on", gates_w, 8'h02);
    check_eq("pchg_state", state_w, 8'h04);
    bus_if.chg_on = 1'b1;
    ticks(2);
    check_eq("pchg_until_filter", gates_w, 8'h02);
    ticks(1);
    check_eq("dead_1_gates", gates_w, 8'h00);
    check_eq("dead_1_state", state_w, 8'h08);
    ticks(1);
    check_eq("dead_2_gates", gates_w, 8'h00);
    check_eq("dead_2_state", state_w, 8'h08);
    ticks(1);
    check_eq("handover_chg", gates_w, 8'h08);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check_eq("handover_off", gates_w, 8'h00);

    // Fault lockout with CHG and DSG on
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(3);
    check_eq("pre_fault_gates", gates_w, 8'h0C);
    bus_if.alert = 1'b1;
    ticks(1);
    check_eq("fault_gates", gates_w, 8'h00);
    check_eq("fault_lock", lock_w, 8'h01);
    check_eq("fault_state", state_w, 8'h00);
    ticks(2);
    bus_if.alert = 1'b0;
    ticks(15);
    check_eq("hold_15_lock", lock_w, 8'h01);
    check_eq("hold_15_gates", gates_w, 8'h00);
    ticks(1);
    check_eq("hold_16_lock", lock_w, 8'h00);
    check_eq("hold_16_gates", gates_w, 8'h00);
    ticks(1);
    check_eq("resume_gates", gates_w, 8'h0C);
    check_eq("resume_state", state_w, 8'h0E);

    // Alert re-pulse at hold count 10 restarts the release count
    bus_if.alert = 1'b1;
    ticks(1);
    bus_if.alert = 1'b0;
    ticks(10);
    bus_if.alert = 1'b1;
    ticks(1);
    check_eq("repulse_lock", lock_w, 8'h01);
    bus_if.alert = 1'b0;
    ticks(15);
    check_eq("repulse_hold_15", lock_w, 8'h01);
    ticks(1);
    check_eq("repulse_release", lock_w, 8'h00);
    ticks(1);
    check_eq("repulse_resume", gates_w, 8'h0C);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check_eq("fault_seq_off", gates_w, 8'h00);

    // Simultaneous CHG, DSG and PDSG requests: paths run independently
    set_req(1'b1, 1'b1, 1'b0, 1'b1);
    ticks(3);
    check_eq("both_start", gates_w, 8'h09);
    check_eq("both_start_state", state_w, 8'h0D);
    ticks(7);
    check_eq("both_pdsg_8", gates_w, 8'h09);
    ticks(1);
    check_eq("both_dsg", gates_w, 8'h0C);
    check_eq("both_dsg_state", state_w, 8'h0E);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    check_eq("final_off", gates_w, 8'h00);

    check_eq("chg_pchg_excl", {7'd0, excl_seen}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fet_gate_sequencer.md
Name: fet_gate_sequencer

Overview:
- Downstream of the BQ76952 monitor model; consumes its per-cycle FET requests (CHG_on, DSG_on, PCHG_on, PDSG_on) and Alert.
- Produces the actual FET gate drives: input debounce, precharge/predischarge sequencing, break-before-make dead time between PCHG and CHG, and fault lockout on Alert.
- Sits between the protection-monitor output and the pack FET power stage in the system bench and RTL.

Parameters:
DEB_CYC, 2, consecutive identical samples required before a filtered request changes (>=1)
DEAD_CYC, 2, cycles with both charge-path gates off when handing PCHG over to CHG (>=1)
PDSG_CYC, 8, minimum cycles PDSG is driven before DSG may turn on (>=1)
FAULT_HOLD, 16, consecutive alert-low cycles needed to release fault lockout (>=1)
CNT_W, 8, width of the internal counters; must hold max(DEB_CYC, DEAD_CYC, PDSG_CYC, FAULT_HOLD)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
chg_on  input  1  raw charge FET request from monitor
dsg_on  input  1  raw discharge FET request
pchg_on  input  1  raw precharge FET request
pdsg_on  input  1  raw predischarge FET request
alert  input  1  monitor alert; level, not debounced
gate_chg  output  1  CHG FET drive
gate_dsg  output  1  DSG FET drive
gate_pchg  output  1  PCHG FET drive
gate_pdsg  output  1  PDSG FET drive
fault_lock  output  1  high while fault lockout is active
c_state  output  2  charge FSM state: 0 C_OFF, 1 C_PCHG, 2 C_DEAD, 3 C_ON
d_state  output  2  discharge FSM state: 0 D_OFF, 1 D_PDSG, 2 D_ON, 3 unused

Behaviour:
- Reset (rst_n low, asynchronous): all gates 0, fault_lock 0, FSMs in OFF, filtered requests 0, all counters 0. Takes effect immediately, mid-sequence included.
- Debounce (per request input):
  - The filtered value takes the raw value at the edge where the raw input has been sampled at that value for DEB_CYC consecutive edges.
  - A glitch shorter than DEB_CYC restarts the count and leaves the filtered value unchanged.
- Latency: if the first edge sampling a new raw value is N, the FSM reacts at N+DEB_CYC and the registered gate output is visible after edge N+DEB_CYC.
- Charge FSM (chg_req / pchg_req are filtered values):
  - C_OFF: chg_req -> C_ON; else pchg_req -> C_PCHG.
  - C_PCHG: gate_pchg=1. chg_req -> C_DEAD (load counter DEAD_CYC); !pchg_req -> C_OFF.
  - C_DEAD: all charge gates 0; counter decrements each cycle; at 0 -> C_ON; chg_req dropping -> C_OFF.
  - C_ON: gate_chg=1; pchg_req ignored; !chg_req -> C_OFF.
  - gate_chg and gate_pchg are never both 1 on any cycle.
- Discharge FSM:
  - D_OFF: dsg_req && !pdsg_req -> D_ON; pdsg_req -> D_PDSG (counter cleared).
  - D_PDSG: gate_pdsg=1; counter increments, saturating at PDSG_CYC.
    - dsg_req && counter==PDSG_CYC -> D_ON. gate_pdsg drops and gate_dsg rises on the same edge.
    - !dsg_req && !pdsg_req -> D_OFF.
  - D_ON: gate_dsg=1; !dsg_req -> D_OFF.
- The two FSMs are independent; simultaneous charge and discharge requests are both honoured.
- Fault:
  - alert sampled 1 at any edge: fault_lock=1, both FSMs forced to OFF, all gates 0 after that same edge. Fault overrides every transition in that cycle.
  - While fault_lock=1, FSMs stay OFF regardless of requests.
  - Release counter counts consecutive edges with alert=0 and restarts on any alert=1. After FAULT_HOLD such edges, fault_lock clears.
  - FSMs resume from OFF using current filtered requests on the next edge. Filters keep running during lockout.
- Counters saturate; they never wrap.
- d_state value 3 is unreachable; if entered, the FSM goes to D_OFF next edge with all discharge gates 0.

Test Plan:
- Reset mid-PDSG (rst_n low at d_state=1, counter=4) -> all gates 0 immediately; after release with pdsg_on=1, counter restarts from 0.
- chg_on 0->1 first sampled at edge 10, DEB_CYC=2 -> gate_chg 1 after edge 12. A 1-cycle chg_on pulse -> gate_chg stays 0.
- pchg_on=1 then chg_on=1 -> gate_pchg 1; on handover gate_pchg 0 for exactly 2 cycles in C_DEAD, then gate_chg 1. gate_chg and gate_pchg never both 1 across the whole run.
- pdsg_on=1 and dsg_on=1 together -> gate_pdsg 1 for 8 cycles, then gate_dsg 1 with gate_pdsg 0 on the same edge. dsg_on dropped at PDSG cycle 5 with pdsg_on still 1 -> stays D_PDSG. Both dropped -> D_OFF.
- gate_chg=1, gate_dsg=1, alert pulse 3 cycles -> all gates 0 after first alert edge, fault_lock 1. Lock clears 16 edges after alert falls; gates return 1 edge later. Alert re-pulse at hold count 10 -> count restarts.
- Simultaneous chg_on, dsg_on, pdsg_on rise -> gate_chg after DEB_CYC edges while discharge path independently runs PDSG 8 cycles then DSG.
